pipe_hazard_ctrl: RTL

Hazard and stall controller for the 5-stage scalar pipeline (IF, ID, EX, MEM, WB). It drives per-register hold and flush controls for the PC and the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), which reset to zero. It resolves three conditions: multi-cycle memory waits, taken-branch squashes and load-use interlocks. It also keeps a memory-timeout error flag and saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage scalar pipeline.
// Drives hold/flush/redirect controls for the PC and inter-stage registers,
// tracks multi-cycle memory waits with a sticky timeout error, and keeps
// saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REGI_CONT   = 4,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [REGI_CONT-1:0] id_rs1_i,
  input  logic [REGI_CONT-1:0] id_rs2_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic [REGI_CONT-1:0] ex_rd_i,
  input  logic                 ex_is_load_i,
  input  logic                 ex_branch_taken_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ack_i,
  output logic                 pc_hold_o,
  output logic                 ifid_hold_o,
  output logic                 idex_hold_o,
  output logic                 exmem_hold_o,
  output logic                 ifid_flush_o,
  output logic                 idex_flush_o,
  output logic                 memwb_flush_o,
  output logic                 pc_redirect_o,
  output logic                 busy_o,
  output logic                 mem_err_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              mem_stall;
  logic              load_use;

  assign mem_stall = mem_req_i & ~mem_ack_i;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_is_load_i && (ex_rd_i != '0) &&
                    ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                     (id_rs2_used_i && (id_rs2_i == ex_rd_i)));

  assign busy_o = (state_q == MEM_WAIT);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next-state and control outputs; freeze has priority, then branch, then load-use
  always_comb begin
    state_d       = state_q;
    pc_hold_o     = 1'b0;
    ifid_hold_o   = 1'b0;
    idex_hold_o   = 1'b0;
    exmem_hold_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    memwb_flush_o = 1'b0;
    pc_redirect_o = 1'b0;
    if (!rst_i) begin
      if ((state_q == RUN && mem_stall) || (state_q == MEM_WAIT && !mem_ack_i)) begin
        pc_hold_o     = 1'b1;
        ifid_hold_o   = 1'b1;
        idex_hold_o   = 1'b1;
        exmem_hold_o  = 1'b1;
        memwb_flush_o = 1'b1;
        state_d       = MEM_WAIT;
      end else begin
        // Ack cycle in MEM_WAIT behaves like RUN without a memory stall
        state_d = RUN;
        if (ex_branch_taken_i) begin
          pc_redirect_o = 1'b1;
          ifid_flush_o  = 1'b1;
          idex_flush_o  = 1'b1;
        end else if (load_use) begin
          pc_hold_o    = 1'b1;
          ifid_hold_o  = 1'b1;
          idex_flush_o = 1'b1;
        end
      end
    end
  end

  // Wait-cycle counter, saturating at the timeout so it never wraps
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else if (state_q == MEM_WAIT && !mem_ack_i) begin
      if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT)) wait_cnt_q <= wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // Sticky timeout error
  always_ff @(posedge clk_i) begin
    if (rst_i)                                                         mem_err_o <= 1'b0;
    else if (state_q == MEM_WAIT && wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) mem_err_o <= 1'b1;
  end

  // Saturating performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (pc_hold_o && stall_cnt_o != '1)     stall_cnt_o <= stall_cnt_o + 1'b1;
      if (pc_redirect_o && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule
